tlb_op_ctrl: RTL
================

// Module: tlb_op_ctrl
// PURPOSE
//  Sequences the CP0 TLB maintenance instructions (TLBP, TLBR, TLBWI, TLBWR) against the mmu TLB ports.
//  Sits between the CP0/EX stage and mmu.
//  - Accepts one op at a time and stalls the pipeline while it runs.
//  - Drives the mmu TLB ports: tlb_p, tlb_we, tlb_we_index, tlb_config, tlb_read_index.
//  - Returns the probe/read result as CP0 write-backs.
//  - Owns the CP0 Random register.
// PARAMETERS
//  TLB_ENTRIES  16                          number of TLB entries; power of two, >= 4
//  IDX_W        $clog2(TLB_ENTRIES)         index width; equals `TLB_WIDTH
// PORTS
//  clk             in   1      clock
//  rst             in   1      asynchronous reset, active-low
//  op_valid        in   1      TLB op request from CP0/EX
//  op_code         in   2      00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
//  op_ready        out  1      controller idle; op accepted when op_valid & op_ready
//  cp0_index       in   IDX_W  CP0 Index[IDX_W-1:0]; sampled at accept
//  cp0_entry       in   86     packed EntryHi/Lo0/Lo1/PageMask; sampled at accept
//  cp0_wired       in   IDX_W  CP0 Wired value
//  cp0_wired_we    in   1      Wired being written this cycle
//  tlb_config      out  86     entry to write (to mmu)
//  tlb_we_index    out  IDX_W  write index (to mmu)
//  tlb_we          out  1      write strobe (to mmu)
//  tlb_p           out  1      probe strobe (to mmu)
//  tlb_p_res_i     in   32     probe result: [31]=miss, [IDX_W-1:0]=hit index
//  tlb_read_index  out  IDX_W  read index (to mmu)
//  tlb_read_cfg_i  in   86     read data (from mmu)
//  done            out  1      one-cycle pulse; op retired
//  index_we        out  1      write index_o to CP0 Index (TLBP)
//  index_o         out  32     Probe result
//  entry_we        out  1      write entry_o to EntryHi/Lo0/Lo1/PageMask (TLBR)
//  entry_o         out  86     read-back entry
//  random_o        out  IDX_W  CP0 Random value
//  mcheck          out  1      one-cycle pulse; duplicate-entry abort (see CONFIGURATION)
// BEHAVIOUR
//  Reset values:
//   - random_o = TLB_ENTRIES-1; state = IDLE.
//   - All strobes, done, index_o and entry_o = 0.
//   - Registered outputs cleared.
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   - op_ready = (state==IDLE).
//   - Accept latches op_code, cp0_index, cp0_entry.
//   - Random snapshot is taken for TLBWR.
//  ISSUE (1 cycle):
//   - TLBP: tlb_p=1.
//   - TLBR: tlb_read_index = latched Index.
//   - TLBWI: tlb_we=1, tlb_we_index = latched Index, tlb_config = latched entry.
//   - TLBWR: as TLBWI, but tlb_we_index = Random snapshot.
//  WAIT (1 cycle):
//   - TLBP: index_o = tlb_p_res_i is registered.
//   - TLBR: entry_o = tlb_read_cfg_i is registered.
//   - Writes: no action.
//  DONE (1 cycle):
//   - done=1.
//   - index_we=1 for TLBP; entry_we=1 for TLBR.
//  Latency: accept to done = 3 cycles for every op; throughput = 1 op per 4 cycles.
//  Strobes are decoded from state, so each is exactly one cycle and never asserted outside ISSUE.
//  Random:
//   - Decrements every cycle.
//   - At random_o == cp0_wired it reloads to TLB_ENTRIES-1 instead (wrap).
//   - If cp0_wired >= TLB_ENTRIES-1, it holds at TLB_ENTRIES-1.
//   - cp0_wired_we reloads it to TLB_ENTRIES-1 and has priority over decrement.
//  Random snapshot is taken at accept; later decrements do not move an in-flight write.
//  op_valid while busy: ignored (stalled); no queueing.
//  op_code out of range: impossible, since 2 bits cover all four ops.
//  Reset mid-op:
//   - Immediate return to IDLE; strobes drop asynchronously.
//   - No done or write-back pulse is produced.
//   - A TLB write is either complete (ISSUE edge passed) or never issued.
// CONFIGURATION
//  Macro TLB_OP_CTRL_DUP_CHECK_EN.
//  Defined:
//   - TLBWI/TLBWR first run an internal probe with cp0_entry: PROBE -> PWAIT states inserted before ISSUE.
//   - If the probe hits at an index != the target index, the write is suppressed (tlb_we stays 0).
//   - On suppression, mcheck pulses with done; the FSM returns to IDLE.
//   - Write latency becomes 5 cycles; TLBP/TLBR are unchanged.
//  Undefined: PROBE/PWAIT are absent and mcheck is tied 0.
// TESTING
//  1. Reset:
//   - rst low for 3 cycles, then release -> random_o=15, op_ready=1, all strobes and write-backs 0.
//  2. TLBWI with Index=5, entry=E:
//   - tlb_we=1 for exactly cycle+1, tlb_we_index=5, tlb_config=E.
//   - done at cycle+3; no index_we or entry_we.
//  3. TLBP on hit at idx 9:
//   - tlb_p_res_i=32'h9 -> index_we with index_o=32'h00000009.
//   - On miss: tlb_p_res_i=32'h80000000 -> index_o=32'h80000000.
//  4. Wired=3, free-run:
//   - random_o sequence 15,14,...,3,15.
//   - cp0_wired_we mid-sequence -> 15 next cycle.
//   - TLBWR writes the Random value captured at accept.
//  5. TLBR Index=2, then assert rst during WAIT:
//   - No done and no entry_we; op_ready=1 after release.
//   - A following TLBR completes normally.
//  6. With TLB_OP_CTRL_DUP_CHECK_EN, TLBWI Index=4 while the same VPN is in entry 7:
//   - tlb_we never 1; mcheck=1 together with done.
//   - With the same VPN at entry 4, the write proceeds.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// -----------------------------------------------------------------------------
// tlb_op_ctrl
//   Sequences the CP0 TLB maintenance instructions (TLBP, TLBR, TLBWI, TLBWR)
//   against the mmu TLB ports. It accepts one op at a time, stalls the pipeline
//   while the op runs, returns probe/read results as CP0 write-backs and owns
//   the CP0 Random register.
//
//   Optional feature macro: TLB_OP_CTRL_DUP_CHECK_EN
//     When defined, TLBWI/TLBWR first run an internal probe (PROBE, PWAIT).
//     If that probe hits an index other than the write target, the write is
//     suppressed and mcheck pulses together with done.
//     When undefined, PROBE/PWAIT do not exist and mcheck is tied to 0.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   op_valid/op_code   op request (00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR)
//   op_ready           controller idle; op accepted on op_valid & op_ready
//   cp0_index/entry    CP0 Index and packed entry, sampled at accept
//   cp0_wired(_we)     CP0 Wired value and its write strobe
//   tlb_*              mmu TLB probe/read/write ports
//   done               one-cycle pulse when an op retires
//   index_we/index_o   probe result write-back to CP0 Index
//   entry_we/entry_o   read result write-back to EntryHi/Lo0/Lo1/PageMask
//   random_o           CP0 Random value
//   mcheck             one-cycle duplicate-entry abort pulse
// -----------------------------------------------------------------------------
module tlb_op_ctrl #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  output logic             op_ready,
  input  logic [IDX_W-1:0] cp0_index,
  input  logic [85:0]      cp0_entry,
  input  logic [IDX_W-1:0] cp0_wired,
  input  logic             cp0_wired_we,
  output logic [85:0]      tlb_config,
  output logic [IDX_W-1:0] tlb_we_index,
  output logic             tlb_we,
  output logic             tlb_p,
  input  logic [31:0]      tlb_p_res_i,
  output logic [IDX_W-1:0] tlb_read_index,
  input  logic [85:0]      tlb_read_cfg_i,
  output logic             done,
  output logic             index_we,
  output logic [31:0]      index_o,
  output logic             entry_we,
  output logic [85:0]      entry_o,
  output logic [IDX_W-1:0] random_o,
  output logic             mcheck
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
`ifdef TLB_OP_CTRL_DUP_CHECK_EN
  localparam logic [2:0] S_PROBE = 3'd4;
  localparam logic [2:0] S_PWAIT = 3'd5;
`endif

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(TLB_ENTRIES - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [1:0]       r_op;
  logic [IDX_W-1:0] r_index;
  logic [85:0]      r_entry;
  logic [IDX_W-1:0] r_rand_snap;
  logic [IDX_W-1:0] r_random;
  logic [31:0]      r_index_o;
  logic [85:0]      r_entry_o;
  logic             w_accept;
  logic             w_is_write;
  logic [IDX_W-1:0] w_target;
  logic             w_we_allow;
  logic             w_probe_extra;

  assign w_accept   = op_valid && (r_state == S_IDLE);
  assign w_is_write = r_op[1];
  // TLBWR targets the Random value frozen at accept, not the live register.
  assign w_target   = (r_op == OP_TLBWR) ? r_rand_snap : r_index;

`ifdef TLB_OP_CTRL_DUP_CHECK_EN
  logic r_dup;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dup <= 1'b0;
    end else if (w_accept) begin
      r_dup <= 1'b0;
    end else if (r_state == S_PWAIT) begin
      // A hit at any index other than the target would create a duplicate.
      r_dup <= !tlb_p_res_i[31] && (tlb_p_res_i[IDX_W-1:0] != w_target);
    end
  end

  assign w_we_allow    = !r_dup;
  assign w_probe_extra = (r_state == S_PROBE);
  assign mcheck        = (r_state == S_DONE) && r_dup;
`else
  assign w_we_allow    = 1'b1;
  assign w_probe_extra = 1'b0;
  assign mcheck        = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef TLB_OP_CTRL_DUP_CHECK_EN
          w_state_nxt = op_code[1] ? S_PROBE : S_ISSUE;
`else
          w_state_nxt = S_ISSUE;
`endif
        end
      end
`ifdef TLB_OP_CTRL_DUP_CHECK_EN
      S_PROBE: w_state_nxt = S_PWAIT;
      S_PWAIT: w_state_nxt = S_ISSUE;
`endif
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_TLBP;
      r_index     <= '0;
      r_entry     <= '0;
      r_rand_snap <= '0;
      r_index_o   <= '0;
      r_entry_o   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op        <= op_code;
        r_index     <= cp0_index;
        r_entry     <= cp0_entry;
        r_rand_snap <= r_random;
      end
      if (r_state == S_WAIT && r_op == OP_TLBP) r_index_o <= tlb_p_res_i;
      if (r_state == S_WAIT && r_op == OP_TLBR) r_entry_o <= tlb_read_cfg_i;
    end
  end

  // Random: wired write and an out-of-range Wired force the top value; reaching
  // Wired wraps to the top; otherwise count down every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_random <= RAND_MAX;
    end else if (cp0_wired_we || (cp0_wired >= RAND_MAX) || (r_random == cp0_wired)) begin
      r_random <= RAND_MAX;
    end else begin
      r_random <= r_random - 1'b1;
    end
  end

  // Strobes decode directly from state so they vanish with an asynchronous reset.
  assign op_ready       = (r_state == S_IDLE);
  assign tlb_p          = ((r_state == S_ISSUE) && (r_op == OP_TLBP)) || w_probe_extra;
  assign tlb_we         = (r_state == S_ISSUE) && w_is_write && w_we_allow;
  assign tlb_we_index   = w_target;
  assign tlb_config     = r_entry;
  assign tlb_read_index = r_index;
  assign done           = (r_state == S_DONE);
  assign index_we       = (r_state == S_DONE) && (r_op == OP_TLBP);
  assign entry_we       = (r_state == S_DONE) && (r_op == OP_TLBR);
  assign index_o        = r_index_o;
  assign entry_o        = r_entry_o;
  assign random_o       = r_random;

endmodule
